// File: rtl/power_sqrt.sv
// Pipelined integer square root: floor(sqrt(power)) and exact remainder, one
// sample per cycle, fixed latency of OUT_W + 2 cycles from in_en to out_en.
module power_sqrt #(
    parameter  int IN_W  = 31,
    localparam int OUT_W = (IN_W + 1) / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   power,
    input  logic              in_en,
    output logic [OUT_W-1:0]  mag,
    output logic [OUT_W:0]    rem,
    output logic              out_en
);

    localparam int R_W = IN_W + 1;
    // Trial values reach bit 2*OUT_W; compare at this width so nothing truncates.
    localparam int T_W = 2 * OUT_W + 1;

    // Index 0 is the input register; index s holds the result after root bit OUT_W-s.
    logic [R_W-1:0]   r_q [0:OUT_W];
    logic [OUT_W-1:0] q_q [0:OUT_W];
    logic [OUT_W:0]   v_q;

    logic [R_W-1:0]   r_d [1:OUT_W];
    logic [OUT_W-1:0] q_d [1:OUT_W];

    logic [OUT_W-1:0] mag_q;
    logic [OUT_W:0]   rem_q;
    logic             out_en_q;

    function automatic logic [T_W-1:0] trial(input logic [OUT_W-1:0] q, input int b);
        return (T_W'(q) << (b + 1)) + (T_W'(1) << (2 * b));
    endfunction

    always_comb begin
        for (int s = 1; s <= OUT_W; s++) begin
            r_d[s] = r_q[s-1];
            q_d[s] = q_q[s-1];
            if (T_W'(r_q[s-1]) >= trial(q_q[s-1], OUT_W - s)) begin
                r_d[s] = R_W'(T_W'(r_q[s-1]) - trial(q_q[s-1], OUT_W - s));
                q_d[s] = q_q[s-1] | (OUT_W'(1) << (OUT_W - s));
            end
        end
    end

    // NOTE: the data pipeline is deliberately left unreset; only valid flags gate
    // what reaches mag/rem, so stale data is harmless and saves reset fan-out.
    always_ff @(posedge clk) begin
        r_q[0] <= R_W'(power);
        q_q[0] <= '0;
        for (int s = 1; s <= OUT_W; s++) begin
            r_q[s] <= r_d[s];
            q_q[s] <= q_d[s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            mag_q    <= '0;
            rem_q    <= '0;
            out_en_q <= 1'b0;
        end else begin
            v_q      <= {v_q[OUT_W-1:0], in_en};
            out_en_q <= v_q[OUT_W];
            if (v_q[OUT_W]) begin
                mag_q <= q_q[OUT_W];
                rem_q <= r_q[OUT_W][OUT_W:0];
            end
        end
    end

    assign mag    = mag_q;
    assign rem    = rem_q;
    assign out_en = out_en_q;

endmodule
